host_cmd_dispatcher: RTL
========================

# host_cmd_dispatcher

Top-level host command dispatcher for the debug/programming subsystem. It owns the UART receive stream while idle and decodes one command byte. It then grants exclusive control to the program loader or to the debug unit, selecting continuous or step execution mode for the latter. When the granted unit reports completion, it drops the grant and returns a status byte to the host over the UART transmitter.

## Interface
Parameters:
- CMD_LOAD, 8'h1C, opcode that grants the program loader
- CMD_RUN, 8'hE1, opcode that grants the debug unit with exec_mode_o=1 (continuous)
- CMD_STEP, 8'hE0, opcode that grants the debug unit with exec_mode_o=0 (step)
- RSP_DONE, 8'hD0, byte sent after a granted unit completes
- RSP_NAK, 8'h15, byte sent for an unknown opcode

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- rx_data_i  in  8  received UART byte
- rx_ready_i  in  1  one-cycle strobe; rx_data_i is valid
- loader_grant_o  out  1  program loader owns the host link
- loader_done_i  in  1  loader finished; level, held while granted
- debug_grant_o  out  1  debug unit owns the host link and the core
- exec_mode_o  out  1  1 = continuous run, 0 = step; valid while debug_grant_o is high
- debug_done_i  in  1  debug unit finished; level, held while granted
- tx_data_o  out  8  response byte to the UART transmitter
- tx_start_o  out  1  one-cycle request to send tx_data_o
- tx_busy_i  in  1  transmitter is occupied
- tx_done_i  in  1  one-cycle strobe; the byte has been sent
- busy_o  out  1  high in every state except S_IDLE

## Operation
States: S_IDLE, S_LOAD, S_DEBUG, S_SEND, S_TX_WAIT.

- **S_IDLE**
  - rx_ready_i=1 with CMD_LOAD -> S_LOAD.
  - rx_ready_i=1 with CMD_RUN -> S_DEBUG; latch exec_mode=1.
  - rx_ready_i=1 with CMD_STEP -> S_DEBUG; latch exec_mode=0.
  - rx_ready_i=1 with any other byte -> S_SEND; latch tx_data=RSP_NAK.
- **S_LOAD**
  - loader_grant_o=1.
  - On loader_done_i=1 -> S_SEND; tx_data=RSP_DONE.
- **S_DEBUG**
  - debug_grant_o=1; exec_mode_o is the latched value.
  - On debug_done_i=1 -> S_SEND; tx_data=RSP_DONE.
- **S_SEND**
  - tx_start_o = !tx_busy_i (combinational).
  - When tx_busy_i=0 -> S_TX_WAIT.
- **S_TX_WAIT**
  - On tx_done_i=1 -> S_IDLE.

General rules:
- Outside S_IDLE the dispatcher ignores rx_ready_i; granted units consume the RX stream themselves.
- Grants are mutually exclusive; both are never high together.
- Grants derive from the registered state only; no input feeds a grant combinationally.
- exec_mode_o is registered. It is 0 whenever debug_grant_o is 0.
- tx_data_o is registered. It holds its value from S_SEND entry through S_TX_WAIT.

## Timing
- Reset (async assert, sync release): state=S_IDLE. All outputs are 0: loader_grant_o, debug_grant_o, exec_mode_o, tx_data_o=8'h00, tx_start_o, busy_o.
- Command byte strobed at edge N -> grant visible after edge N, i.e. one cycle of latency. The granted unit never sees the opcode strobe.
- done_i sampled high at edge M -> grant low after edge M, same edge S_SEND is entered.
  - With tx_busy_i=0, tx_start_o is high for exactly one cycle, in the cycle after edge M.
- tx_busy_i high in S_SEND -> tx_start_o stays low. The dispatcher waits indefinitely and the byte is not lost.
- tx_done_i arriving in any state other than S_TX_WAIT is ignored.
- rx_ready_i pulse coinciding with the S_TX_WAIT -> S_IDLE edge is dropped. A byte is accepted only when sampled in S_IDLE.
- done_i already high on the cycle the grant is asserted: exit at the next edge. Minimum grant width is 1 cycle.
- Reset asserted mid-grant or mid-send drops the grant immediately (asynchronously). No response byte is sent.

## Test plan
- Reset, then idle: all outputs 0 and busy_o=0. rx_ready_i with 8'h55 -> S_SEND; next cycle tx_start_o=1 with tx_data_o=8'h15; tx_done_i -> busy_o=0.
- Send 8'hE1: next cycle debug_grant_o=1, exec_mode_o=1, loader_grant_o=0. Hold for 10 cycles, then debug_done_i=1 -> grant drops; tx_start_o one cycle with 8'hD0; tx_done_i -> idle.
- Send 8'hE0: debug_grant_o=1, exec_mode_o=0. Send rx byte 8'hAE while granted -> no state change, busy_o=1. debug_done_i -> response 8'hD0.
- Send 8'h1C: loader_grant_o=1, debug_grant_o=0. Hold tx_busy_i=1 when loader_done_i rises -> tx_start_o stays 0 for 5 cycles. Release tx_busy_i -> single tx_start_o pulse with 8'hD0.
- Back-to-back: 8'hE1, then rx_ready_i=1 with 8'h1C on the same cycle as tx_done_i -> byte dropped and still idle. Resend 8'h1C -> loader granted.
- Assert rst_ni=0 mid S_DEBUG -> debug_grant_o and exec_mode_o go 0 without waiting for a clock edge. After release: idle, no tx_start_o pulse.

Source files
------------

// File: rtl/host_cmd_dispatcher.sv
// Host command dispatcher: decodes one opcode byte from the UART while idle,
// grants the loader or debug unit, then returns a status byte over the UART.
module host_cmd_dispatcher #(
    parameter logic [7:0] CMD_LOAD = 8'h1C,
    parameter logic [7:0] CMD_RUN  = 8'hE1,
    parameter logic [7:0] CMD_STEP = 8'hE0,
    parameter logic [7:0] RSP_DONE = 8'hD0,
    parameter logic [7:0] RSP_NAK  = 8'h15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_ready_i,
    output logic       loader_grant_o,
    input  logic       loader_done_i,
    output logic       debug_grant_o,
    output logic       exec_mode_o,
    input  logic       debug_done_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    input  logic       tx_busy_i,
    input  logic       tx_done_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DEBUG,
        S_SEND,
        S_TX_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic       exec_mode_q, exec_mode_d;
    logic [7:0] tx_data_q, tx_data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            exec_mode_q <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            exec_mode_q <= exec_mode_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exec_mode_d = exec_mode_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (rx_ready_i) begin
                    if (rx_data_i == CMD_LOAD) begin
                        state_d = S_LOAD;
                    end else if (rx_data_i == CMD_RUN) begin
                        state_d     = S_DEBUG;
                        exec_mode_d = 1'b1;
                    end else if (rx_data_i == CMD_STEP) begin
                        state_d     = S_DEBUG;
                        exec_mode_d = 1'b0;
                    end else begin
                        state_d   = S_SEND;
                        tx_data_d = RSP_NAK;
                    end
                end
            end
            S_LOAD: begin
                if (loader_done_i) begin
                    state_d   = S_SEND;
                    tx_data_d = RSP_DONE;
                end
            end
            S_DEBUG: begin
                // Clear the mode with the grant so exec_mode_o never outlives it.
                if (debug_done_i) begin
                    state_d     = S_SEND;
                    tx_data_d   = RSP_DONE;
                    exec_mode_d = 1'b0;
                end
            end
            S_SEND: begin
                if (!tx_busy_i) state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign loader_grant_o = (state_q == S_LOAD);
    assign debug_grant_o  = (state_q == S_DEBUG);
    assign exec_mode_o    = exec_mode_q;
    assign tx_data_o      = tx_data_q;
    assign tx_start_o     = (state_q == S_SEND) && !tx_busy_i;
    assign busy_o         = (state_q != S_IDLE);

endmodule
